cpu_run_ctrl: RTL and testbench

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for a soft CPU: synchronizes and debounces front-panel
// buttons, sequences CPU reset, and stops execution on a breakpoint address match.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter int unsigned RESET_HOLD_CYCLES = 8
) (
    input  logic        CLK100MHZ,
    input  logic        RST_N,
    input  logic        BTN_RUN,
    input  logic        BTN_STEP,
    input  logic        BTN_HALT,
    input  logic        SW_RESET,
    input  logic        SW_BP_EN,
    input  logic [31:0] BP_ADDR,
    input  logic [31:0] IMEM_ADDR,
    output logic        CPU_RST_N,
    output logic        CPU_HALT,
    output logic [1:0]  STATE,
    output logic [15:0] CYCLE_COUNT,
    output logic        BP_HIT
);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW  = $clog2(RESET_HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RESET_HOLD = 2'b00,
        S_HALTED     = 2'b01,
        S_RUN        = 2'b10,
        S_STEP       = 2'b11
    } state_t;

    // Bit order: {bp_en, sw_reset, halt, step, run}
    logic [4:0] sync1, sync2;

    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {SW_BP_EN, SW_RESET, BTN_HALT, BTN_STEP, BTN_RUN};
            sync2 <= sync1;
        end
    end

    logic [2:0] btn_press;

    for (genvar g = 0; g < 3; g++) begin : g_debounce
        logic           deb;
        logic           pulse;
        logic [DBW-1:0] cnt;

        always_ff @(posedge CLK100MHZ or negedge RST_N) begin
            if (!RST_N) begin
                deb   <= 1'b0;
                pulse <= 1'b0;
                cnt   <= '0;
            end else begin
                pulse <= 1'b0;
                if (sync2[g] == deb) begin
                    cnt <= '0;
                end else if (cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb   <= sync2[g];
                    pulse <= sync2[g];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign btn_press[g] = pulse;
    end

    state_t        state, state_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic          first_run;
    logic          bp_match;
    logic          bp_hit_nx;

    always_comb begin
        state_nx  = state;
        hold_nx   = hold_cnt;
        bp_hit_nx = BP_HIT;
        bp_match  = sync2[4] && (IMEM_ADDR == BP_ADDR) && !first_run;

        if (sync2[3]) begin
            state_nx = S_RESET_HOLD;
            hold_nx  = '0;
        end else begin
            case (state)
                S_RESET_HOLD: begin
                    if (hold_cnt == HW'(RESET_HOLD_CYCLES - 1)) begin
                        state_nx = S_HALTED;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
                S_HALTED: begin
                    if (btn_press[1])      state_nx = S_STEP;
                    else if (btn_press[0]) state_nx = S_RUN;
                end
                S_RUN: begin
                    if (bp_match) begin
                        state_nx  = S_HALTED;
                        bp_hit_nx = 1'b1;
                    end else if (btn_press[2]) begin
                        state_nx = S_HALTED;
                    end
                end
                default: state_nx = S_HALTED;
            endcase
        end

        if (state_nx == S_RESET_HOLD ||
            (state != S_RUN && (state_nx == S_RUN || state_nx == S_STEP)))
            bp_hit_nx = 1'b0;
    end

    // Output flops are loaded from the next state so STATE/CPU_RST_N/CPU_HALT always agree.
    always_ff @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_RESET_HOLD;
            hold_cnt    <= '0;
            first_run   <= 1'b0;
            CPU_RST_N   <= 1'b0;
            CPU_HALT    <= 1'b1;
            CYCLE_COUNT <= '0;
            BP_HIT      <= 1'b0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            first_run <= (state_nx == S_RUN) && (state != S_RUN);
            CPU_RST_N <= (state_nx != S_RESET_HOLD);
            CPU_HALT  <= !(state_nx == S_RUN || state_nx == S_STEP);
            BP_HIT    <= bp_hit_nx;
            if (state_nx == S_RESET_HOLD)
                CYCLE_COUNT <= '0;
            else if (!CPU_HALT)
                CYCLE_COUNT <= CYCLE_COUNT + 16'd1;
        end
    end

    assign STATE = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus randomized traffic
// compared against a sample-window behavioural model.
module tb_cpu_run_ctrl;
    localparam int DB   = 16;
    localparam int HOLD = 8;

    logic        CLK100MHZ = 1'b0;
    logic        RST_N     = 1'b0;
    logic        BTN_RUN   = 1'b0;
    logic        BTN_STEP  = 1'b0;
    logic        BTN_HALT  = 1'b0;
    logic        SW_RESET  = 1'b0;
    logic        SW_BP_EN  = 1'b0;
    logic [31:0] BP_ADDR   = '0;
    logic [31:0] IMEM_ADDR = '0;
    logic        CPU_RST_N;
    logic        CPU_HALT;
    logic [1:0]  STATE;
    logic [15:0] CYCLE_COUNT;
    logic        BP_HIT;

    int checks = 0;
    int passed = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES  (DB),
        .RESET_HOLD_CYCLES(HOLD)
    ) dut (
        .CLK100MHZ  (CLK100MHZ),
        .RST_N      (RST_N),
        .BTN_RUN    (BTN_RUN),
        .BTN_STEP   (BTN_STEP),
        .BTN_HALT   (BTN_HALT),
        .SW_RESET   (SW_RESET),
        .SW_BP_EN   (SW_BP_EN),
        .BP_ADDR    (BP_ADDR),
        .IMEM_ADDR  (IMEM_ADDR),
        .CPU_RST_N  (CPU_RST_N),
        .CPU_HALT   (CPU_HALT),
        .STATE      (STATE),
        .CYCLE_COUNT(CYCLE_COUNT),
        .BP_HIT     (BP_HIT)
    );

    // Reference model: a button level flips once the last DB synchronized samples
    // all disagree with it; mode is 0 hold, 1 halted, 2 run, 3 step.
    int m_state = 0, m_hold = 0, m_cc = 0, m_ns = 0;
    bit m_first = 0, m_bp = 0, m_diff, m_bpm, m_running;
    bit m_d1[5], m_d2[5], m_s[5];
    bit m_deb[3], m_rose[3], m_pr[3];
    bit m_win[3][$];

    always @(posedge CLK100MHZ or negedge RST_N) begin
        if (!RST_N) begin
            m_state = 0; m_hold = 0; m_cc = 0; m_first = 0; m_bp = 0;
            for (int i = 0; i < 5; i++) begin m_d1[i] = 0; m_d2[i] = 0; end
            for (int b = 0; b < 3; b++) begin m_deb[b] = 0; m_rose[b] = 0; m_win[b].delete(); end
        end else begin
            m_s  = m_d2;
            m_d2 = m_d1;
            m_d1 = '{BTN_RUN, BTN_STEP, BTN_HALT, SW_RESET, SW_BP_EN};
            m_pr = m_rose;
            for (int b = 0; b < 3; b++) begin
                m_rose[b] = 0;
                m_win[b].push_back(m_s[b]);
                if (m_win[b].size() > DB) void'(m_win[b].pop_front());
                m_diff = (m_win[b].size() == DB);
                for (int k = 0; k < m_win[b].size(); k++)
                    if (m_win[b][k] == m_deb[b]) m_diff = 0;
                if (m_diff) begin
                    m_deb[b]  = !m_deb[b];
                    m_rose[b] = m_deb[b];
                end
            end
            m_running = (m_state >= 2);
            m_bpm = m_s[4] && (IMEM_ADDR == BP_ADDR) && m_state == 2 && !m_first;
            m_ns = m_state;
            if (m_s[3]) begin
                m_ns = 0; m_hold = 0;
            end else if (m_state == 0) begin
                m_hold++;
                if (m_hold == HOLD) begin m_ns = 1; m_hold = 0; end
            end else if (m_state == 1) begin
                if (m_pr[1]) m_ns = 3; else if (m_pr[0]) m_ns = 2;
            end else if (m_state == 2) begin
                if (m_bpm || m_pr[2]) m_ns = 1;
                if (m_bpm) m_bp = 1;
            end else begin
                m_ns = 1;
            end
            if (m_ns == 0) begin m_cc = 0; m_bp = 0; end
            else if (m_running) m_cc = (m_cc + 1) % 65536;
            if (m_ns >= 2 && m_ns != m_state) m_bp = 0;
            m_first = (m_ns == 2 && m_state != 2);
            m_state = m_ns;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    task automatic wait_state(input logic [1:0] st, input int limit, output bit ok);
        int n = 0;
        while (STATE !== st && n < limit) begin @(negedge CLK100MHZ); n++; end
        ok = (STATE === st);
    endtask

    task automatic test_reset();
        int n = 0;
        cyc(3);
        checks++; if (STATE !== 2'b00) $display("FAIL rst_state: got %b want 00", STATE); else passed++;
        checks++; if (CPU_RST_N !== 1'b0) $display("FAIL rst_cpu_rst_n: got %b want 0", CPU_RST_N); else passed++;
        checks++; if (CPU_HALT !== 1'b1) $display("FAIL rst_halt: got %b want 1", CPU_HALT); else passed++;
        checks++; if (CYCLE_COUNT !== 16'h0) $display("FAIL rst_cc: got %h want 0000", CYCLE_COUNT); else passed++;
        checks++; if (BP_HIT !== 1'b0) $display("FAIL rst_bp: got %b want 0", BP_HIT); else passed++;
        RST_N = 1'b1;
        while (CPU_RST_N !== 1'b1 && n < 30) begin @(negedge CLK100MHZ); n++; end
        checks++; if (n != HOLD) $display("FAIL hold_len: got %0d cycles want %0d", n, HOLD); else passed++;
        checks++; if (STATE !== 2'b01) $display("FAIL hold_exit_state: got %b want 01", STATE); else passed++;
        checks++; if (CPU_HALT !== 1'b1) $display("FAIL hold_exit_halt: got %b want 1", CPU_HALT); else passed++;
        checks++; if (CYCLE_COUNT !== 16'h0) $display("FAIL hold_exit_cc: got %h want 0000", CYCLE_COUNT); else passed++;
    endtask

    task automatic test_step_bounce();
        int runs = 0;
        int base = m_cc;
        for (int i = 0; i < 3; i++) begin
            BTN_STEP = 1'b1; cyc(1); if (CPU_HALT === 1'b0) runs++;
            BTN_STEP = 1'b0; cyc(1); if (CPU_HALT === 1'b0) runs++;
        end
        BTN_STEP = 1'b1;
        repeat (40) begin cyc(1); if (CPU_HALT === 1'b0) runs++; end
        BTN_STEP = 1'b0;
        repeat (25) begin cyc(1); if (CPU_HALT === 1'b0) runs++; end
        checks++; if (runs != 1) $display("FAIL step_runs: got %0d want 1", runs); else passed++;
        checks++; if (CYCLE_COUNT !== 16'((base + 1) % 65536)) $display("FAIL step_cc: got %0d want %0d", CYCLE_COUNT, (base + 1) % 65536); else passed++;
        checks++; if (STATE !== 2'b01) $display("FAIL step_state: got %b want 01", STATE); else passed++;
    endtask

    task automatic test_simultaneous();
        int runs = 0, steps = 0, rstate = 0;
        BTN_STEP = 1'b1; BTN_RUN = 1'b1;
        repeat (30) begin
            cyc(1);
            if (CPU_HALT === 1'b0) runs++;
            if (STATE === 2'b11) steps++;
            if (STATE === 2'b10) rstate++;
        end
        BTN_STEP = 1'b0; BTN_RUN = 1'b0;
        repeat (25) begin cyc(1); if (CPU_HALT === 1'b0) runs++; if (STATE === 2'b10) rstate++; end
        checks++; if (steps != 1) $display("FAIL simul_step: got %0d step cycles want 1", steps); else passed++;
        checks++; if (runs != 1) $display("FAIL simul_runs: got %0d want 1", runs); else passed++;
        checks++; if (rstate != 0) $display("FAIL simul_norun: got %0d run cycles want 0", rstate); else passed++;
    endtask

    task automatic test_breakpoint();
        int idx = 0, n = 0, base;
        bit ok;
        SW_BP_EN = 1'b1; BP_ADDR = 32'd2; IMEM_ADDR = 32'hFFFF_FFFF;
        cyc(3);
        base = m_cc;
        BTN_RUN = 1'b1;
        while (n < 100) begin
            @(negedge CLK100MHZ); n++;
            if (STATE === 2'b10) begin IMEM_ADDR = idx; idx++; end
            else if (idx > 0) break;
        end
        checks++; if (STATE !== 2'b01) $display("FAIL bp_stop_state: got %b want 01", STATE); else passed++;
        checks++; if (CPU_HALT !== 1'b1) $display("FAIL bp_stop_halt: got %b want 1", CPU_HALT); else passed++;
        checks++; if (BP_HIT !== 1'b1) $display("FAIL bp_hit_set: got %b want 1", BP_HIT); else passed++;
        checks++; if (CYCLE_COUNT !== 16'((base + 3) % 65536)) $display("FAIL bp_cc: got %0d want %0d", CYCLE_COUNT, (base + 3) % 65536); else passed++;
        BTN_RUN = 1'b0; IMEM_ADDR = 32'd2;
        cyc(25);
        BTN_RUN = 1'b1;
        wait_state(2'b10, 60, ok);
        checks++; if (!ok) $display("FAIL bp_resume_wait: got state %b want 10", STATE); else passed++;
        cyc(1);
        checks++; if (STATE !== 2'b10) $display("FAIL bp_no_retrigger: got %b want 10", STATE); else passed++;
        checks++; if (BP_HIT !== 1'b0) $display("FAIL bp_clear_on_run: got %b want 0", BP_HIT); else passed++;
        cyc(1);
        checks++; if (BP_HIT !== 1'b1) $display("FAIL bp_second_hit: got %b want 1", BP_HIT); else passed++;
        BTN_RUN = 1'b0; SW_BP_EN = 1'b0;
        cyc(25);
    endtask

    task automatic test_sw_reset();
        int n = 0;
        bit ok;
        BTN_RUN = 1'b1;
        wait_state(2'b10, 60, ok);
        checks++; if (!ok) $display("FAIL swr_run_wait: got state %b want 10", STATE); else passed++;
        BTN_RUN = 1'b0;
        cyc(10);
        SW_RESET = 1'b1;
        while (STATE !== 2'b00 && n < 10) begin @(negedge CLK100MHZ); n++; end
        checks++; if (n > 3) $display("FAIL swr_latency: got %0d cycles want <=3", n); else passed++;
        checks++; if (CPU_RST_N !== 1'b0) $display("FAIL swr_cpu_rst_n: got %b want 0", CPU_RST_N); else passed++;
        checks++; if (CYCLE_COUNT !== 16'h0) $display("FAIL swr_cc: got %h want 0000", CYCLE_COUNT); else passed++;
        cyc(4);
        SW_RESET = 1'b0;
        n = 0;
        while (STATE !== 2'b01 && n < 30) begin @(negedge CLK100MHZ); n++; end
        checks++; if (n != HOLD + 2) $display("FAIL swr_hold: got %0d cycles want %0d", n, HOLD + 2); else passed++;
    endtask

    task automatic test_async_reset();
        bit ok;
        BTN_RUN = 1'b1;
        wait_state(2'b10, 60, ok);
        checks++; if (!ok) $display("FAIL arst_run_wait: got state %b want 10", STATE); else passed++;
        BTN_RUN = 1'b0;
        cyc(3);
        #2 RST_N = 1'b0;
        #1;
        checks++; if (STATE !== 2'b00) $display("FAIL arst_state: got %b want 00", STATE); else passed++;
        checks++; if (CPU_HALT !== 1'b1) $display("FAIL arst_halt: got %b want 1", CPU_HALT); else passed++;
        checks++; if (CPU_RST_N !== 1'b0) $display("FAIL arst_cpu_rst_n: got %b want 0", CPU_RST_N); else passed++;
        checks++; if (CYCLE_COUNT !== 16'h0) $display("FAIL arst_cc: got %h want 0000", CYCLE_COUNT); else passed++;
        cyc(3);
        RST_N = 1'b1;
        wait_state(2'b01, 20, ok);
        checks++; if (!ok) $display("FAIL arst_recover: got state %b want 01", STATE); else passed++;
    endtask

    task automatic test_wrap();
        bit ok;
        SW_BP_EN = 1'b0;
        BTN_RUN = 1'b1;
        wait_state(2'b10, 60, ok);
        checks++; if (!ok) $display("FAIL wrap_run_wait: got state %b want 10", STATE); else passed++;
        BTN_RUN = 1'b0;
        cyc(65537);
        BTN_HALT = 1'b1;
        wait_state(2'b01, 60, ok);
        checks++; if (!ok) $display("FAIL wrap_halt_wait: got state %b want 01", STATE); else passed++;
        BTN_HALT = 1'b0;
        cyc(25);
        checks++; if (CYCLE_COUNT !== 16'(m_cc)) $display("FAIL wrap_cc: got %h want %h", CYCLE_COUNT, 16'(m_cc)); else passed++;
    endtask

    task automatic test_random();
        int seg;
        for (int s = 0; s < 150; s++) begin
            BTN_RUN  = ($urandom_range(0, 2) == 0);
            BTN_STEP = ($urandom_range(0, 3) == 0);
            BTN_HALT = ($urandom_range(0, 3) == 0);
            SW_RESET = ($urandom_range(0, 19) == 0);
            SW_BP_EN = ($urandom_range(0, 1) == 1);
            BP_ADDR  = $urandom_range(0, 3);
            seg = $urandom_range(1, 45);
            repeat (seg) begin
                @(negedge CLK100MHZ);
                checks++; if (STATE !== 2'(m_state)) $display("FAIL rnd_state: got %b want %b", STATE, 2'(m_state)); else passed++;
                checks++; if (CPU_RST_N !== (m_state != 0)) $display("FAIL rnd_cpu_rst_n: got %b want %b", CPU_RST_N, m_state != 0); else passed++;
                checks++; if (CPU_HALT !== (m_state < 2)) $display("FAIL rnd_halt: got %b want %b", CPU_HALT, m_state < 2); else passed++;
                checks++; if (CYCLE_COUNT !== 16'(m_cc)) $display("FAIL rnd_cc: got %h want %h", CYCLE_COUNT, 16'(m_cc)); else passed++;
                checks++; if (BP_HIT !== m_bp) $display("FAIL rnd_bp: got %b want %b", BP_HIT, m_bp); else passed++;
                IMEM_ADDR = $urandom_range(0, 3);
            end
        end
        BTN_RUN = 1'b0; BTN_STEP = 1'b0; BTN_HALT = 1'b0; SW_RESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step_bounce();
        test_simultaneous();
        test_breakpoint();
        test_sw_reset();
        test_async_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
